lsu_arbiter: RTL and testbench

Two-requester arbiter that shares the single LSU (data memory plus memory-mapped LEDs, HEX, LCD and switches) between the core's load/store stage (port 0) and a secondary master such as a debug loader or DMA (port 1). It accepts one request at a time with round-robin fairness and drives the LSU command for exactly one cycle per store, so each peripheral register sees a single write. It holds a read's command stable for the LSU read latency, then returns the data to the winning port.

---
 rtl/lsu_arbiter.sv | 147 ++++++++++++++
 tb/tb_lsu_arbiter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_arbiter.sv
// Round-robin arbiter sharing one LSU between the load/store stage (port 0) and a secondary master (port 1).
// One access at a time: 1-cycle ISSUE, RD_LAT-cycle WAIT for loads, load data returned one cycle after capture.
module lsu_arbiter #(
  parameter int unsigned RD_LAT = 1
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_m0_req,
  input  logic [31:0] i_m0_addr,
  input  logic [31:0] i_m0_wdata,
  input  logic        i_m0_wren,
  input  logic [2:0]  i_m0_func3,
  input  logic        i_m1_req,
  input  logic [31:0] i_m1_addr,
  input  logic [31:0] i_m1_wdata,
  input  logic        i_m1_wren,
  input  logic [2:0]  i_m1_func3,
  output logic        o_m0_gnt,
  output logic        o_m1_gnt,
  output logic        o_m0_rvalid,
  output logic        o_m1_rvalid,
  output logic [31:0] o_m0_rdata,
  output logic [31:0] o_m1_rdata,
  output logic [31:0] o_lsu_addr,
  output logic [31:0] o_st_data,
  output logic        o_lsu_wren,
  output logic [2:0]  o_func3,
  input  logic [31:0] i_ld_data,
  output logic        o_busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_e;

  localparam logic [1:0] LAST_CNT = (RD_LAT == 0) ? 2'd0 : 2'(RD_LAT - 1);

  state_e      state_q, state_d;
  logic        ptr_q, ptr_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        wren_q, wren_d;
  logic [2:0]  func3_q, func3_d;
  logic        port_q, port_d;
  logic [1:0]  rvalid_q, rvalid_d;
  logic [31:0] rdata0_q, rdata0_d;
  logic [31:0] rdata1_q, rdata1_d;
  logic        pick1;
  logic        capture;

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wren_d   = wren_q;
    func3_d  = func3_q;
    port_d   = port_q;
    rvalid_d = 2'b00;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    capture  = 1'b0;
    // ptr_q holds the last granted port; on a tie the other one wins
    pick1    = i_m1_req & (~i_m0_req | ~ptr_q);

    case (state_q)
      IDLE: begin
        if (i_m0_req | i_m1_req) begin
          port_d  = pick1;
          ptr_d   = pick1;
          addr_d  = pick1 ? i_m1_addr  : i_m0_addr;
          wdata_d = pick1 ? i_m1_wdata : i_m0_wdata;
          wren_d  = pick1 ? i_m1_wren  : i_m0_wren;
          func3_d = pick1 ? i_m1_func3 : i_m0_func3;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d = 2'd0;
        if (wren_q) begin
          state_d = IDLE;
        end else if (RD_LAT == 0) begin
          capture = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == LAST_CNT) begin
          capture = 1'b1;
          cnt_d   = 2'd0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (capture) begin
      rvalid_d[port_q] = 1'b1;
      if (port_q) rdata1_d = i_ld_data;
      else        rdata0_d = i_ld_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q  <= IDLE;
      ptr_q    <= 1'b1;
      cnt_q    <= 2'd0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wren_q   <= 1'b0;
      func3_q  <= '0;
      port_q   <= 1'b0;
      rvalid_q <= 2'b00;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wren_q   <= wren_d;
      func3_q  <= func3_d;
      port_q   <= port_d;
      rvalid_q <= rvalid_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  assign o_m0_gnt    = (state_q == ISSUE) & ~port_q;
  assign o_m1_gnt    = (state_q == ISSUE) &  port_q;
  assign o_lsu_wren  = (state_q == ISSUE) &  wren_q;
  assign o_busy      = (state_q != IDLE);
  assign o_lsu_addr  = addr_q;
  assign o_st_data   = wdata_q;
  assign o_func3     = func3_q;
  assign o_m0_rvalid = rvalid_q[0];
  assign o_m1_rvalid = rvalid_q[1];
  assign o_m0_rdata  = rdata0_q;
  assign o_m1_rdata  = rdata1_q;

endmodule

// File: tb/tb_lsu_arbiter.sv
// Bench for lsu_arbiter: three instances (RD_LAT 0, 1, 3), each with its own LSU model,
// checked against a transaction-level schedule of grants, store pulses and load returns.
module tb_lsu_arbiter;

  localparam logic [31:0] SW_VAL = 32'h0000_0155;
  localparam logic [31:0] DEAD   = 32'hDEAD_BEEF;

  typedef struct {
    bit          v;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          wren;
    logic [2:0]  f3;
  } req_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  rst_n;
  logic [2:0]  m0_req, m1_req, m0_wren, m1_wren;
  logic [31:0] m0_addr [3], m1_addr [3], m0_wdata [3], m1_wdata [3];
  logic [2:0]  m0_f3 [3], m1_f3 [3];
  logic [2:0]  m0_gnt, m1_gnt, m0_rv, m1_rv, lsu_wren, busy;
  logic [31:0] m0_rdata [3], m1_rdata [3], lsu_addr [3], st_data [3], ld_data [3];
  logic [2:0]  f3_out [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    lsu_arbiter #(.RD_LAT((g == 0) ? 0 : ((g == 1) ? 1 : 3))) u_dut (
      .i_clk      (clk),
      .i_reset    (rst_n[g]),
      .i_m0_req   (m0_req[g]),
      .i_m0_addr  (m0_addr[g]),
      .i_m0_wdata (m0_wdata[g]),
      .i_m0_wren  (m0_wren[g]),
      .i_m0_func3 (m0_f3[g]),
      .i_m1_req   (m1_req[g]),
      .i_m1_addr  (m1_addr[g]),
      .i_m1_wdata (m1_wdata[g]),
      .i_m1_wren  (m1_wren[g]),
      .i_m1_func3 (m1_f3[g]),
      .o_m0_gnt   (m0_gnt[g]),
      .o_m1_gnt   (m1_gnt[g]),
      .o_m0_rvalid(m0_rv[g]),
      .o_m1_rvalid(m1_rv[g]),
      .o_m0_rdata (m0_rdata[g]),
      .o_m1_rdata (m1_rdata[g]),
      .o_lsu_addr (lsu_addr[g]),
      .o_st_data  (st_data[g]),
      .o_lsu_wren (lsu_wren[g]),
      .o_func3    (f3_out[g]),
      .i_ld_data  (ld_data[g]),
      .o_busy     (busy[g])
    );
  end

  function automatic int lat_of(input int k);
    return (k == 0) ? 0 : ((k == 1) ? 1 : 3);
  endfunction

  // LSU environment: word memory, LEDR, HEX1, switches; load data valid RD_LAT cycles after the command
  logic        env_clr;
  logic [31:0] lsu_mem [3][64];
  logic [31:0] ledr [3];
  logic [7:0]  hex1 [3];
  int          wcnt [3];
  logic [31:0] pipe [3][3];

  function automatic logic [31:0] lookup(input int k, input logic [31:0] a);
    if (a == 32'h1001_0000) return SW_VAL;
    return lsu_mem[k][a[7:2]];
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (env_clr) begin
        for (int i = 0; i < 64; i++) lsu_mem[k][i] <= '0;
        ledr[k] <= '0;
        hex1[k] <= '0;
        wcnt[k] <= 0;
      end else if (lsu_wren[k]) begin
        wcnt[k] <= wcnt[k] + 1;
        if (lsu_addr[k] == 32'h1000_0000)      ledr[k] <= st_data[k];
        else if (lsu_addr[k] == 32'h1000_2001) hex1[k] <= st_data[k][7:0];
        else if (lsu_addr[k][31:8] == 24'h0)   lsu_mem[k][lsu_addr[k][7:2]] <= st_data[k];
      end
      pipe[k][0] <= ((m0_gnt[k] | m1_gnt[k]) & ~lsu_wren[k]) ? lookup(k, lsu_addr[k]) : DEAD;
      pipe[k][1] <= pipe[k][0];
      pipe[k][2] <= pipe[k][1];
    end
  end

  always_comb begin
    for (int k = 0; k < 3; k++) begin
      ld_data[k] = DEAD;
      if (lat_of(k) == 0) begin
        if ((m0_gnt[k] | m1_gnt[k]) & ~lsu_wren[k]) ld_data[k] = lookup(k, lsu_addr[k]);
      end else begin
        ld_data[k] = pipe[k][lat_of(k) - 1];
      end
    end
  end

  // Reference model state: memory contents and last granted port per instance
  logic [31:0] ref_mem [3][64];
  int          last [3];
  int          n_chk = 0;
  int          n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic req_t mk(input bit v, input logic [31:0] a, input logic [31:0] d,
                              input bit w, input logic [2:0] f);
    req_t r;
    r.v = v; r.addr = a; r.wdata = d; r.wren = w; r.f3 = f;
    return r;
  endfunction

  function automatic logic [31:0] ref_load(input int k, input logic [31:0] a);
    if (a == 32'h1001_0000) return SW_VAL;
    return ref_mem[k][a[7:2]];
  endfunction

  function automatic logic any_out(input int k);
    return |{m0_gnt[k], m1_gnt[k], m0_rv[k], m1_rv[k], m0_rdata[k], m1_rdata[k],
             lsu_addr[k], st_data[k], lsu_wren[k], f3_out[k], busy[k]};
  endfunction

  // Cycle 0 is the sampling cycle; the schedule is built from the access rules, then compared cycle by cycle
  task automatic run_txn(input int k, input req_t q0, input req_t q1);
    bit          eg0 [32], eg1 [32], ewr [32], erv0 [32], erv1 [32];
    logic [31:0] ea [32], ed [32];
    logic [2:0]  ef [32];
    logic [31:0] erd0, erd1;
    req_t        q;
    int          s, w, g;
    bit          p0, p1;
    for (int i = 0; i < 32; i++) begin
      eg0[i] = 0; eg1[i] = 0; ewr[i] = 0; erv0[i] = 0; erv1[i] = 0;
      ea[i] = '0; ed[i] = '0; ef[i] = '0;
    end
    erd0 = '0; erd1 = '0;
    s = 0; p0 = q0.v; p1 = q1.v;
    while (p0 || p1) begin
      if (p0 && p1) w = (last[k] == 0) ? 1 : 0;
      else          w = p0 ? 0 : 1;
      last[k] = w;
      q = (w == 0) ? q0 : q1;
      g = s + 1;
      if (w == 0) begin eg0[g] = 1; p0 = 0; end
      else        begin eg1[g] = 1; p1 = 0; end
      ea[g] = q.addr; ed[g] = q.wdata; ef[g] = q.f3; ewr[g] = q.wren;
      if (q.wren) begin
        if (q.addr[31:8] == 24'h0) ref_mem[k][q.addr[7:2]] = q.wdata;
        s = s + 2;
      end else begin
        s = s + 2 + lat_of(k);
        if (w == 0) begin erv0[s] = 1; erd0 = ref_load(k, q.addr); end
        else        begin erv1[s] = 1; erd1 = ref_load(k, q.addr); end
      end
    end

    m0_req[k] = q0.v; m0_addr[k] = q0.addr; m0_wdata[k] = q0.wdata; m0_wren[k] = q0.wren; m0_f3[k] = q0.f3;
    m1_req[k] = q1.v; m1_addr[k] = q1.addr; m1_wdata[k] = q1.wdata; m1_wren[k] = q1.wren; m1_f3[k] = q1.f3;
    for (int c = 0; c <= s; c++) begin
      chk($sformatf("k%0d c%0d gnt0", k, c), m0_gnt[k], eg0[c]);
      chk($sformatf("k%0d c%0d gnt1", k, c), m1_gnt[k], eg1[c]);
      chk($sformatf("k%0d c%0d wren", k, c), lsu_wren[k], ewr[c]);
      chk($sformatf("k%0d c%0d rvalid0", k, c), m0_rv[k], erv0[c]);
      chk($sformatf("k%0d c%0d rvalid1", k, c), m1_rv[k], erv1[c]);
      if (eg0[c] || eg1[c]) begin
        chk($sformatf("k%0d c%0d lsu_addr", k, c), lsu_addr[k], ea[c]);
        chk($sformatf("k%0d c%0d st_data", k, c), st_data[k], ed[c]);
        chk($sformatf("k%0d c%0d func3", k, c), f3_out[k], ef[c]);
      end
      if (erv0[c]) chk($sformatf("k%0d c%0d rdata0", k, c), m0_rdata[k], erd0);
      if (erv1[c]) chk($sformatf("k%0d c%0d rdata1", k, c), m1_rdata[k], erd1);
      if (m0_gnt[k]) m0_req[k] = 1'b0;
      if (m1_gnt[k]) m1_req[k] = 1'b0;
      tick;
    end
    m0_req[k] = 1'b0;
    m1_req[k] = 1'b0;
    tick;
  endtask

  req_t none;
  int   wc;
  int   pat;

  initial begin
    none    = mk(0, '0, '0, 0, '0);
    rst_n   = 3'b000;
    env_clr = 1'b1;
    m0_req  = '0; m1_req = '0; m0_wren = '0; m1_wren = '0;
    for (int k = 0; k < 3; k++) begin
      m0_addr[k] = '0; m1_addr[k] = '0; m0_wdata[k] = '0; m1_wdata[k] = '0;
      m0_f3[k] = '0; m1_f3[k] = '0;
      last[k] = 1;
      for (int i = 0; i < 64; i++) ref_mem[k][i] = '0;
    end
    repeat (3) tick;
    for (int k = 0; k < 3; k++) chk($sformatf("k%0d reset outputs", k), any_out(k), 0);
    env_clr = 1'b0;
    rst_n   = 3'b111;
    tick; tick;

    // SW to LEDR: single wren pulse, LEDR takes the value
    wc = wcnt[1];
    run_txn(1, mk(1, 32'h1000_0000, 32'h0000_00AA, 1, 3'b010), none);
    chk("ledr", ledr[1], 32'h0000_00AA);
    chk("ledr wren pulses", wcnt[1] - wc, 1);

    // m1 LW after seeding memory through m0
    run_txn(1, mk(1, 32'h0000_0010, 32'h1234_5678, 1, 3'b010), none);
    run_txn(1, none, mk(1, 32'h0000_0010, 32'h0, 0, 3'b010));

    // Both ports storing: grants alternate
    run_txn(1, mk(1, 32'h0000_0020, 32'h11, 1, 3'b010), mk(1, 32'h0000_0024, 32'h22, 1, 3'b010));
    run_txn(1, mk(1, 32'h0000_0028, 32'h33, 1, 3'b010), mk(1, 32'h0000_002C, 32'h44, 1, 3'b010));

    // SB to HEX1 then LW from switches
    wc = wcnt[1];
    run_txn(1, mk(1, 32'h1000_2001, 32'h0000_0079, 1, 3'b000), none);
    chk("hex1", hex1[1], 8'h79);
    chk("hex1 wren pulses", wcnt[1] - wc, 1);
    run_txn(1, mk(1, 32'h1001_0000, 32'h0, 0, 3'b010), none);

    // Load-after-store at RD_LAT 0 and 3
    run_txn(0, mk(1, 32'h0000_0030, 32'hCAFE_0001, 1, 3'b010), none);
    run_txn(0, mk(1, 32'h0000_0030, 32'h0, 0, 3'b010), none);
    run_txn(2, mk(1, 32'h0000_0030, 32'hCAFE_0003, 1, 3'b010), none);
    run_txn(2, mk(1, 32'h0000_0030, 32'h0, 0, 3'b010), none);

    // Reset during WAIT of an m0 load on the RD_LAT 3 instance
    m0_addr[2] = 32'h0000_0030; m0_wren[2] = 1'b0; m0_f3[2] = 3'b010; m0_req[2] = 1'b1;
    tick;
    chk("rst-mid gnt0", m0_gnt[2], 1);
    m0_req[2] = 1'b0;
    tick;
    chk("rst-mid busy", busy[2], 1);
    rst_n[2] = 1'b0;
    #1;
    chk("rst-mid outputs", any_out(2), 0);
    tick; tick;
    rst_n[2] = 1'b1;
    last[2]  = 1;
    for (int c = 0; c < 8; c++) begin
      tick;
      chk($sformatf("rst-mid no rvalid c%0d", c), m0_rv[2] | m1_rv[2], 0);
    end
    run_txn(2, mk(1, 32'h0000_0030, 32'h0, 0, 3'b010), none);

    // Randomized traffic on all three latencies
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 25; i++) begin
        pat = $urandom_range(1, 3);
        run_txn(k,
          mk(pat[0], $urandom_range(0, 15) * 4, $urandom, 1'($urandom_range(0, 1)), 3'b010),
          mk(pat[1], $urandom_range(0, 15) * 4, $urandom, 1'($urandom_range(0, 1)), 3'b010));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
